// File: rtl/vmicro16_apb_arbiter_pkg.sv
// Shared definitions for the vmicro16 APB arbiter.
//   - arb_state_t    : APB sequencing states (IDLE / SETUP / ACCESS)
//   - DEF_AW/DEF_DW  : default address / data widths
//   - TIMEOUT_CNT_W  : width of the ACCESS-phase watchdog counter
//   - TIMEOUT_RDATA  : read data returned to a master whose transfer timed out
//   - ptr_width()    : width of a master index for a given master count
package vmicro16_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    localparam int DEF_AW        = 16;
    localparam int DEF_DW        = 16;
    localparam int TIMEOUT_CNT_W = 8;

    localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_apb_arbiter_rr_pick.sv
// Combinational rotating priority encoder.
// Returns the first set bit of req at or after index ptr, wrapping modulo NCORES.
// Ports:
//   req   in  NCORES  request vector
//   ptr   in  PW      index with highest priority
//   pick  out NCORES  one-hot winner (0 when nothing requests)
//   valid out 1       at least one request present
module vmicro16_rr_pick
    import vmicro16_apb_arbiter_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int PW     = ptr_width(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NCORES-1:0] pick,
    output logic              valid
);

    localparam int              IDXW = PW + 1;
    localparam logic [IDXW-1:0] NC   = IDXW'(NCORES);

    // rot[k] is the request of master (ptr + k) mod NCORES, so bit 0 of
    // rot is the highest-priority master this cycle.
    logic [NCORES-1:0] rot;
    logic [NCORES-1:0] rot_pick;

    // Isolate the lowest set bit of the rotated vector.
    assign rot_pick = rot & (~rot + NCORES'(1));
    assign valid    = |req;

    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_lane
            logic [IDXW-1:0] fwd_sum;
            logic [IDXW-1:0] bwd_sum;
            logic [PW-1:0]   fwd_idx;
            logic [PW-1:0]   bwd_idx;

            // Forward map: rotated lane gi reads master (ptr + gi) mod N.
            assign fwd_sum = {1'b0, ptr} + IDXW'(gi);
            assign fwd_idx = (fwd_sum >= NC) ? PW'(fwd_sum - NC) : PW'(fwd_sum);
            assign rot[gi] = req[fwd_idx];

            // Inverse map: master gi sits at rotated lane (gi - ptr) mod N.
            assign bwd_sum = IDXW'(gi + NCORES) - {1'b0, ptr};
            assign bwd_idx = (bwd_sum >= NC) ? PW'(bwd_sum - NC) : PW'(bwd_sum);
            assign pick[gi] = rot_pick[bwd_idx];
        end
    endgenerate

endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter sharing one APB3 master port between NCORES core masters.
// A granted request is sequenced through SETUP and ACCESS; completion is
// returned only to the owner. Back-to-back grants skip IDLE when another
// master is waiting; the finishing master is masked from that hand-over.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   defined   : ACCESS phase is limited to TIMEOUT cycles; on expiry the owner
//               gets S_PREADY with S_PRDATA = 16'hDEAD and timeout_err sets
//               (sticky until reset); the bus then returns to IDLE.
//   undefined : ACCESS waits indefinitely, timeout_err is tied low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   S_PADDR/S_PWRITE/S_PSEL/S_PWDATA   per-master request side (master i at slice i)
//   S_PRDATA, S_PREADY    read data broadcast, one-hot completion to owner
//   M_PADDR/M_PWRITE/M_PSEL/M_PENABLE/M_PWDATA   shared APB master port
//   M_PRDATA, M_PREADY    response from interconnect
//   grant                 one-hot current owner, 0 when idle
//   timeout_err           sticky timeout flag
module vmicro16_apb_arbiter
    import vmicro16_apb_arbiter_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORES*AW-1:0] S_PADDR,
    input  logic [NCORES-1:0]    S_PWRITE,
    input  logic [NCORES-1:0]    S_PSEL,
    input  logic [NCORES*DW-1:0] S_PWDATA,
    output logic [DW-1:0]        S_PRDATA,
    output logic [NCORES-1:0]    S_PREADY,
    output logic [AW-1:0]        M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSEL,
    output logic                 M_PENABLE,
    output logic [DW-1:0]        M_PWDATA,
    input  logic [DW-1:0]        M_PRDATA,
    input  logic                 M_PREADY,
    output logic [NCORES-1:0]    grant,
    output logic                 timeout_err
);

    localparam int            PW   = ptr_width(NCORES);
    localparam logic [PW-1:0] LAST = PW'(NCORES - 1);

    generate
        if (NCORES < 2 || NCORES > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("vmicro16_apb_arbiter: NCORES or TIMEOUT out of range");
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic [NCORES-1:0] grant_q, grant_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [AW-1:0]     paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DW-1:0]     pwdata_q, pwdata_d;

    logic              in_access;
    logic              xfer_done;
    logic              tmo_hit;
    logic              load_winner;
    logic [PW-1:0]     rr_after;
    logic [NCORES-1:0] pick_req;
    logic [PW-1:0]     pick_ptr;
    logic [NCORES-1:0] pick;
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;

    assign in_access = (state_q == ST_ACCESS);
    assign xfer_done = in_access && (M_PREADY || tmo_hit);
    assign rr_after  = (owner_q == LAST) ? '0 : owner_q + PW'(1);

    // On a completion cycle the finishing master still holds S_PSEL; mask it
    // and search from the slot after it so the hand-over is fair without an
    // IDLE bubble.
    assign pick_req = in_access ? (S_PSEL & ~grant_q) : S_PSEL;
    assign pick_ptr = in_access ? rr_after : rr_q;

    vmicro16_rr_pick #(
        .NCORES (NCORES),
        .PW     (PW)
    ) u_rr_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (pick[k]) begin
                pick_idx = PW'(k);
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     timeout_err_q;

    // Counter is 0 on the first ACCESS cycle, so TIMEOUT-1 marks the last one.
    assign tmo_hit = in_access && !M_PREADY && (tmo_cnt_q == TIMEOUT_CNT_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_SETUP) begin
            tmo_cnt_d = '0;
        end else if (in_access) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
    assign S_PRDATA    = tmo_hit ? DW'(TIMEOUT_RDATA) : M_PRDATA;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign S_PRDATA    = M_PRDATA;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        load_winner = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_SETUP;
                    load_winner = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_done) begin
                    rr_d = rr_after;
                    // A timed-out transfer always parks the bus for a cycle.
                    if (pick_valid && !tmo_hit) begin
                        state_d     = ST_SETUP;
                        load_winner = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (load_winner) begin
            grant_d  = pick;
            owner_d  = pick_idx;
            paddr_d  = S_PADDR[pick_idx*AW +: AW];
            pwrite_d = S_PWRITE[pick_idx];
            pwdata_d = S_PWDATA[pick_idx*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Completion is suppressed while reset is asserted so an aborted
    // transfer never reports done.
    assign S_PREADY  = (xfer_done && !reset) ? grant_q : '0;
    assign M_PSEL    = (state_q != ST_IDLE);
    assign M_PENABLE = in_access;
    assign M_PADDR   = paddr_q;
    assign M_PWRITE  = pwrite_q;
    assign M_PWDATA  = pwdata_q;
    assign grant     = grant_q;

endmodule
